// File: rtl/io_pkg.sv
// io_pkg: shared constants for the CPU IO region.
// Holds the data width and the addr[7:2] codes decoded by the input-port
// block (0xC0..0xCC) and the output-port block (0x80..0x88).
package io_pkg;

  localparam int DATA_W = 32;

  // Input-port block codes (addr[7:2])
  localparam logic [5:0] IN_PORT0  = 6'b110000;  // 0xC0
  localparam logic [5:0] IN_PORT1  = 6'b110001;  // 0xC4
  localparam logic [5:0] IN_PORT2  = 6'b110010;  // 0xC8
  localparam logic [5:0] IN_STATUS = 6'b110011;  // 0xCC

  // Output-port block codes (addr[7:2]), decoded elsewhere
  localparam logic [5:0] OUT_PORT0 = 6'b100000;  // 0x80
  localparam logic [5:0] OUT_PORT1 = 6'b100001;  // 0x84
  localparam logic [5:0] OUT_PORT2 = 6'b100010;  // 0x88

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/io_input_port.sv
// io_input_port: one asynchronous input port.
// Purpose: synchronizes port_i through SYNC_STAGES flops, accepts the
// synchronized value into val_o (optionally after debounce) and keeps a
// sticky change flag chg_o that clr_i clears (a same-edge set wins).
// Optional feature: define IO_INPUT_DEBOUNCE_EN to require DEBOUNCE_CYCLES
// consecutive stable edges before a new value is accepted.
// Ports:
//   clk_i    clock, all state updates on rising edge
//   rst_ni   synchronous active-low reset
//   port_i   external input, asynchronous to clk_i
//   clr_i    clear request for the change flag
//   val_o    accepted value
//   chg_o    sticky change flag
module io_input_port
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] port_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] val_o,
  output logic              chg_o
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("io_input_port: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] sync_s;
  logic [DATA_W-1:0] val_q, val_d;
  logic              chg_q, chg_d;
  logic              set_s;

  // Synchronizer chain; reset discards any in-flight samples
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= port_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Debounce: a new candidate restarts the count; a candidate that differs
  // from val and has been stable for DEBOUNCE_CYCLES edges is accepted
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    val_d  = val_q;
    set_s  = 1'b0;
    if (sync_s != cand_q) begin
      cand_d = sync_s;
      cnt_d  = {CNT_W{1'b0}};
    end else if (cand_q != val_q && cnt_q == CNT_LAST) begin
      val_d  = cand_q;
      cnt_d  = {CNT_W{1'b0}};
      set_s  = 1'b1;
    end else if (cand_q != val_q) begin
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d  = {CNT_W{1'b0}};
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cand_q <= '0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  // Direct acceptance: any difference at the synchronizer output is taken
  always_comb begin
    val_d = val_q;
    set_s = 1'b0;
    if (sync_s != val_q) begin
      val_d = sync_s;
      set_s = 1'b1;
    end else begin
      val_d = val_q;
      set_s = 1'b0;
    end
  end
`endif

  // Change flag: set has priority over a same-edge clear
  always_comb begin
    chg_d = chg_q;
    if (set_s) begin
      chg_d = 1'b1;
    end else if (clr_i) begin
      chg_d = 1'b0;
    end else begin
      chg_d = chg_q;
    end
  end

  // Accepted value and change flag registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      val_q <= '0;
      chg_q <= 1'b0;
    end else begin
      val_q <= val_d;
      chg_q <= chg_d;
    end
  end

  assign val_o = val_q;
  assign chg_o = chg_q;

endmodule

// File: rtl/io_input.sv
// io_input: memory-mapped input-port block for the single-period CPU.
// Purpose: three synchronized input ports plus a sticky change-status word,
// returned on the CPU load path. Reading 0xCC with read_io_enable=1 clears
// the change flags on that edge (the read itself returns pre-clear flags).
// Optional feature: IO_INPUT_DEBOUNCE_EN enables per-port debounce.
// Ports:
//   io_clk          sole clock
//   resetn          synchronous active-low reset
//   addr            CPU data address, decoded on addr[7:2]
//   read_io_enable  load strobe, qualifies clear-on-read only
//   in_port0..2     asynchronous external inputs
//   io_read_data    combinational read mux over registered state
//   change_irq      OR of the change flags
module io_input
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic        read_io_enable,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] in_port2,
  output logic [31:0] io_read_data,
  output logic        change_irq
);

  logic [5:0]        code_s;
  logic              clr_s;
  logic [DATA_W-1:0] val0_s, val1_s, val2_s;
  logic [2:0]        chg_s;
  logic              unused_addr_s;

  assign code_s        = addr[7:2];
  assign unused_addr_s = ^{addr[31:8], addr[1:0]};
  assign clr_s         = read_io_enable & (code_s == IN_STATUS);

  io_input_port #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_port0 (
    .clk_i (io_clk),
    .rst_ni(resetn),
    .port_i(in_port0),
    .clr_i (clr_s),
    .val_o (val0_s),
    .chg_o (chg_s[0])
  );

  io_input_port #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_port1 (
    .clk_i (io_clk),
    .rst_ni(resetn),
    .port_i(in_port1),
    .clr_i (clr_s),
    .val_o (val1_s),
    .chg_o (chg_s[1])
  );

  io_input_port #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_port2 (
    .clk_i (io_clk),
    .rst_ni(resetn),
    .port_i(in_port2),
    .clr_i (clr_s),
    .val_o (val2_s),
    .chg_o (chg_s[2])
  );

  // Read mux; independent of read_io_enable
  always_comb begin
    io_read_data = 32'h0000_0000;
    case (code_s)
      IN_PORT0:  io_read_data = val0_s;
      IN_PORT1:  io_read_data = val1_s;
      IN_PORT2:  io_read_data = val2_s;
      IN_STATUS: io_read_data = {29'b0, chg_s};
      default:   io_read_data = 32'h0000_0000;
    endcase
  end

  assign change_irq = |chg_s;

endmodule

// File: tb/tb_io_input.sv
// tb_io_input: directed, table-driven bench for io_input.
module tb_io_input;

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] in_port0, in_port1, in_port2;
  logic [31:0] io_read_data;
  logic        change_irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [11];

  always #5 io_clk = ~io_clk;

  io_input dut (
    .io_clk        (io_clk),
    .resetn        (resetn),
    .addr          (addr),
    .read_io_enable(read_io_enable),
    .in_port0      (in_port0),
    .in_port1      (in_port1),
    .in_port2      (in_port2),
    .io_read_data  (io_read_data),
    .change_irq    (change_irq)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic en);
    addr           = a;
    read_io_enable = en;
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h0000_00C0, 32'h0000_FFFF};
    tbl[1]  = '{32'h0000_00C4, 32'h0000_0AAA};
    tbl[2]  = '{32'h0000_00C8, 32'h5A5A_5A5A};
    tbl[3]  = '{32'h0000_00CC, 32'h0000_0004};
    tbl[4]  = '{32'h0000_00C3, 32'h0000_FFFF};
    tbl[5]  = '{32'h0000_01C4, 32'h0000_0AAA};
    tbl[6]  = '{32'h0000_0080, 32'h0000_0000};
    tbl[7]  = '{32'h0000_00D0, 32'h0000_0000};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0000};
    tbl[9]  = '{32'h0000_0084, 32'h0000_0000};
    tbl[10] = '{32'h0000_00FC, 32'h0000_0000};

    resetn         = 1'b0;
    addr           = 32'h0;
    read_io_enable = 1'b0;
    in_port0       = 32'hDEAD_BEEF;
    in_port1       = 32'h0;
    in_port2       = 32'h0;

    // Reset held for 3 edges
    repeat (3) tick();
    rd(32'hC0, 1'b0); chk("rst_val0", io_read_data, 32'h0);
    rd(32'hC4, 1'b0); chk("rst_val1", io_read_data, 32'h0);
    rd(32'hC8, 1'b0); chk("rst_val2", io_read_data, 32'h0);
    rd(32'hCC, 1'b0); chk("rst_status", io_read_data, 32'h0);
    chk("rst_irq", {31'b0, change_irq}, 32'h0);

    // Release; DEADBEEF appears on the LAT-th edge
    resetn = 1'b1;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      rd(32'hC0, 1'b0);
      chk($sformatf("rel_val0_e%0d", e), io_read_data, (e < LAT) ? 32'h0 : 32'hDEAD_BEEF);
    end
    rd(32'hCC, 1'b0); chk("rel_status", io_read_data, 32'h1);
    chk("rel_irq", {31'b0, change_irq}, 32'h1);

    // Clear-on-read returns pre-clear flags
    rd(32'hCC, 1'b1); chk("clr_pre", io_read_data, 32'h1);
    tick();
    rd(32'hCC, 1'b0); chk("clr_post", io_read_data, 32'h0);
    chk("clr_irq", {31'b0, change_irq}, 32'h0);

    // Latency on port1
    in_port1 = 32'h55;
    for (int e = 1; e <= LAT; e++) begin
      tick();
      rd(32'hC4, 1'b0);
      chk($sformatf("lat_val1_e%0d", e), io_read_data, (e < LAT) ? 32'h0 : 32'h55);
      chk($sformatf("lat_irq_e%0d", e), {31'b0, change_irq}, (e < LAT) ? 32'h0 : 32'h1);
    end
    rd(32'hCC, 1'b1); tick(); rd(32'hCC, 1'b0);
    chk("lat_cleared", io_read_data, 32'h0);

    // chg=101, read without enable keeps flags, with enable clears
    in_port0 = 32'h1234_5678;
    in_port2 = 32'hA5A5_A5A5;
    repeat (LAT) tick();
    rd(32'hCC, 1'b0); chk("c101_status", io_read_data, 32'h5);
    tick();
    chk("c101_noen", io_read_data, 32'h5);
    rd(32'hCC, 1'b1); chk("c101_pre", io_read_data, 32'h5);
    tick();
    rd(32'hCC, 1'b0); chk("c101_post", io_read_data, 32'h0);
    chk("c101_irq", {31'b0, change_irq}, 32'h0);

    // Set beats clear on chg2
    in_port0 = 32'h0000_FFFF;
    in_port1 = 32'h0000_0AAA;
    repeat (LAT) tick();
    rd(32'hCC, 1'b0); chk("sbc_pre_status", io_read_data, 32'h3);
    in_port2 = 32'h5A5A_5A5A;
    repeat (LAT - 1) tick();
    rd(32'hCC, 1'b1); chk("sbc_read", io_read_data, 32'h3);
    tick();
    rd(32'hCC, 1'b0); chk("sbc_post", io_read_data, 32'h4);
    chk("sbc_irq", {31'b0, change_irq}, 32'h1);

    // Decode table
    for (int i = 0; i < 11; i++) begin
      rd(tbl[i].a, 1'b0);
      chk($sformatf("dec_%h", tbl[i].a), io_read_data, tbl[i].exp);
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    // Short glitch is never accepted
    rd(32'hCC, 1'b1); tick(); rd(32'hCC, 1'b0);
    in_port0 = 32'hFFFF_0000;
    repeat (2) tick();
    in_port0 = 32'h0000_FFFF;
    repeat (12) tick();
    rd(32'hC0, 1'b0); chk("glitch_val0", io_read_data, 32'h0000_FFFF);
    rd(32'hCC, 1'b0); chk("glitch_status", io_read_data, 32'h0);
`endif

    // Mid-operation reset discards in-flight data
    in_port1 = 32'h77;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rd(32'hC0, 1'b0); chk("mid_val0", io_read_data, 32'h0);
    rd(32'hC4, 1'b0); chk("mid_val1", io_read_data, 32'h0);
    rd(32'hCC, 1'b0); chk("mid_status", io_read_data, 32'h0);
    chk("mid_irq", {31'b0, change_irq}, 32'h0);
    repeat (LAT - 1) tick();
    rd(32'hC4, 1'b0); chk("mid_early", io_read_data, 32'h0);
    tick();
    chk("mid_reacq", io_read_data, 32'h77);
    rd(32'hCC, 1'b0); chk("mid_reacq_status", io_read_data, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
